div_result_buffer: RTL and testbench
====================================

// Module: div_result_buffer
// PURPOSE
//  Output stage directly downstream of the pipelined signed divider.
//  - Captures each {Coc, Res} pair the divider presents with Done into an output FIFO.
//  - Re-times results onto a valid/ready interface.
//  - Issues credits (can_issue) to the operand source so results in flight never overflow the FIFO.
//  - The divider pipeline has no back-pressure; this block is its only flow control.
// PARAMETERS
//  tamanyo  32  operand/result width; equals the divider's tamanyo
//  DEPTH    8   result FIFO entries, power of two, >=2
//  CW       $clog2(DEPTH+1)  localparam, width of occupancy and in-flight counters
// PORTS
//  CLK        in   1        clock
//  RSTa       in   1        synchronous active-low reset
//  issue      in   1        source drove START into the divider this cycle
//  div_done   in   1        divider result valid this cycle (Done)
//  div_coc    in   tamanyo  divider quotient (Coc)
//  div_res    in   tamanyo  divider remainder (Res)
//  can_issue  out  1        a START is permitted this cycle
//  out_valid  out  1        out_coc/out_res hold the oldest result
//  out_ready  in   1        consumer accepts the head result
//  out_coc    out  tamanyo  quotient at FIFO head
//  out_res    out  tamanyo  remainder at FIFO head
//  occupancy  out  CW       results stored in the FIFO
//  err_ovf    out  1        sticky: issue while !can_issue, or div_done while full with no pop
//  err_unf    out  1        sticky: div_done while inflight==0
// BEHAVIOUR
//  - One clock (CLK). Reset is synchronous, active-low on RSTa, sampled at posedge CLK.
//  - Reset values: pointers, occupancy and inflight = 0; out_valid=0; can_issue=0 during reset, 1 the cycle after.
//    err_ovf=0, err_unf=0. out_coc/out_res = 0.
//  - Reset mid-operation discards all stored and in-flight results.
//    Any div_done after reset for a pre-reset issue sets err_unf.
//  - inflight counter (CW bits):
//    - +1 on issue, -1 on div_done.
//    - Simultaneous issue and div_done leaves it unchanged.
//  - can_issue = (occupancy + inflight) < DEPTH.
//    - Combinational from registered counters only; no path from issue or out_ready.
//  - Push: div_done writes {div_coc, div_res} at the tail on the same posedge.
//    - Result is visible on out_* with out_valid=1 the next cycle (latency 1).
//  - Pop: the head advances on posedge when out_valid && out_ready.
//    - Next entry is presented the following cycle.
//    - out_* hold stable while out_valid && !out_ready.
//  - Simultaneous push and pop: occupancy unchanged.
//    - When full, the push is accepted because the pop frees the slot.
//    - When empty, the push is accepted and the pop is impossible (out_valid=0).
//  - Push while full with no pop: data dropped, FIFO unchanged, err_ovf set.
//  - div_done with inflight==0: data still pushed if space, err_unf set, inflight stays 0.
//  - issue with !can_issue: inflight still increments, err_ovf set.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//    Full/empty are decided by occupancy, not pointer equality.
//  - Error flags clear only on reset.
// STRUCTURE
//  - Shared package div_pkg:
//    - tamanyo default.
//    - typedef struct packed {logic [tamanyo-1:0] coc, res;} div_result_t.
//    - Localparam DIV_LATENCY = 2*tamanyo, for benches.
//  - Sub-module div_fifo_sync: DEPTH x div_result_t register-array FIFO with push/pop/occupancy.
//  - Top level holds the inflight counter, credit logic and error flags.
// TESTING
//  1. Reset, then issue 1 op (7/2); div_done 64 cycles later with coc=3 res=1
//     -> out_valid next cycle, out=3/1; inflight back to 0; can_issue=1 throughout.
//  2. Issue 8 back-to-back with out_ready=0 -> can_issue falls after the 8th issue.
//     All 8 results are stored, occupancy=8, no error flag.
//  3. Full FIFO, out_ready=1 and div_done in the same cycle -> occupancy stays 8.
//     The new result lands at the tail and pop order is preserved (FIFO order check).
//  4. Full FIFO, out_ready=0, forced div_done -> err_ovf=1, stored data unchanged.
//     Forced issue with can_issue=0 also sets err_ovf.
//  5. div_done with nothing issued -> err_unf=1; also assert RSTa=0 for 1 cycle with 3 in flight.
//     Then occupancy=0, out_valid=0, and later stray dones set err_unf.
//  6. Random issue/out_ready over 10k cycles with divider model (Num=-9, Den=2 -> -4/-1, etc.)
//     -> scoreboard matches in order, occupancy+inflight<=DEPTH always.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider result path.
// Result record, default width and nominal divider latency.
package div_pkg;

  localparam int DIV_TAMANYO = 32;
  localparam int DIV_DEPTH   = 8;
  localparam int DIV_LATENCY = 2 * DIV_TAMANYO;

  typedef struct packed {
    logic [DIV_TAMANYO-1:0] coc;
    logic [DIV_TAMANYO-1:0] res;
  } div_result_t;

  function automatic int div_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/div_fifo_sync.sv
// Register-array FIFO for divider results.
// Full/empty come from the occupancy count, not pointer compare.
module div_fifo_sync
  import div_pkg::*;
#(
  parameter type T     = div_result_t,
  parameter int  DEPTH = DIV_DEPTH,
  localparam int CW    = div_cnt_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty     = (occ_q == '0);
  assign full      = (occ_q == CW'(DEPTH));
  assign occupancy = occ_q;
  assign rdata     = empty ? T'('0) : mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/div_result_buffer.sv
// Output stage behind the pipelined divider: result FIFO,
// valid/ready re-timing, issue credits and sticky error flags.
module div_result_buffer
  import div_pkg::*;
#(
  parameter int  tamanyo = DIV_TAMANYO,
  parameter int  DEPTH   = DIV_DEPTH,
  localparam int CW      = div_cnt_width(DEPTH)
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               issue,
  input  logic               div_done,
  input  logic [tamanyo-1:0] div_coc,
  input  logic [tamanyo-1:0] div_res,
  output logic               can_issue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [tamanyo-1:0] out_coc,
  output logic [tamanyo-1:0] out_res,
  output logic [CW-1:0]      occupancy,
  output logic               err_ovf,
  output logic               err_unf
);

  typedef struct packed {
    logic [tamanyo-1:0] coc;
    logic [tamanyo-1:0] res;
  } res_t;

  res_t          wdata;
  res_t          rdata;
  logic          full;
  logic          empty;
  logic          pop;
  logic [CW:0]   credit_sum;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;

  assign wdata = '{coc: div_coc, res: div_res};

  div_fifo_sync #(
    .T     (res_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTa),
    .push      (div_done),
    .pop       (pop),
    .wdata     (wdata),
    .rdata     (rdata),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_coc   = rdata.coc;
  assign out_res   = rdata.res;
  assign pop       = out_valid && out_ready;

  // Credits come only from registered counters; held low in reset.
  assign credit_sum = {1'b0, occupancy} + {1'b0, inflight_q};
  assign can_issue  = RSTa && (credit_sum < (CW+1)'(DEPTH));

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, div_done})
      2'b10: inflight_d = inflight_q + CW'(1);
      2'b01: begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - CW'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase
    err_ovf_d = err_ovf_q
              | (issue && !can_issue)
              | (div_done && full && !pop);
    err_unf_d = err_unf_q | (div_done && (inflight_q == '0));
  end

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      inflight_q <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed table plus corner-case sequences and a randomised
// divider model with an in-order scoreboard.
module tb_div_result_buffer;
  import div_pkg::*;

  localparam int W   = 32;
  localparam int D   = 8;
  localparam int LAT = DIV_LATENCY;

  logic         CLK = 1'b0;
  logic         RSTa;
  logic         issue, div_done, out_ready;
  logic [W-1:0] div_coc, div_res;
  logic         can_issue, out_valid, err_ovf, err_unf;
  logic [W-1:0] out_coc, out_res;
  logic [3:0]   occupancy;

  div_result_buffer #(.tamanyo(W), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RSTa      (RSTa),
    .issue     (issue),
    .div_done  (div_done),
    .div_coc   (div_coc),
    .div_res   (div_res),
    .can_issue (can_issue),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coc   (out_coc),
    .out_res   (out_res),
    .occupancy (occupancy),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic         iss, dn, rdy;
    logic [W-1:0] coc, res;
    logic         ev;
    logic [W-1:0] ecoc, eres;
    logic [3:0]   eocc;
    logic         ecan, eovf, eunf;
  } row_t;

  typedef struct {
    int           due;
    logic [W-1:0] coc, res;
  } pend_t;

  row_t  tbl[$];
  pend_t pend[$];
  pend_t sb[$];

  function automatic row_t mk(input logic iss, dn, rdy,
                              input int coc, res,
                              input logic ev, input int ecoc, eres,
                              input int eocc,
                              input logic ecan, eovf, eunf);
    row_t r;
    r.iss = iss; r.dn = dn; r.rdy = rdy;
    r.coc = W'(coc); r.res = W'(res);
    r.ev = ev; r.ecoc = W'(ecoc); r.eres = W'(eres);
    r.eocc = 4'(eocc);
    r.ecan = ecan; r.eovf = eovf; r.eunf = eunf;
    return r;
  endfunction

  function automatic logic [71:0] snap();
    return {out_valid, out_coc, out_res, occupancy,
            can_issue, err_ovf, err_unf};
  endfunction

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    issue = 0; div_done = 0; out_ready = 0;
    div_coc = '0; div_res = '0;
  endtask

  task automatic do_reset();
    idle();
    RSTa = 0;
    step();
    RSTa = 1;
    step();
  endtask

  initial begin
    int bad;
    int viol;
    int infl;
    int num, den;
    idle();
    RSTa = 0;
    step();
    step();
    chk("reset_state", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b000});
    RSTa = 1;
    step();
    chk("can_after_reset", {71'd0, can_issue}, 72'd1);

    // Single op: issue, result 64 cycles later.
    issue = 1;
    step();
    issue = 0;
    bad = 0;
    for (int i = 0; i < LAT - 1; i++) begin
      if (can_issue !== 1'b1) bad++;
      step();
    end
    chk("can_throughout", 72'(bad), 72'd0);
    div_done = 1; div_coc = 3; div_res = 1;
    step();
    div_done = 0;
    chk("single_result", snap(), {1'b1, 32'd3, 32'd1, 4'd1, 3'b100});
    out_ready = 1;
    step();
    out_ready = 0;
    chk("single_pop", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b100});

    // Fill, full push+pop, dropped push, drain in order.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, k < 7, 0, 0));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(0, 1, 0, 10 + j, j, 1, 10, 0, j + 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 30, 30, 1, 11, 1, 8, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 40, 40, 1, 11, 1, 8, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 11, 1, 8, 0, 1, 1));
    for (int m = 0; m < 8; m++) begin
      int h;
      h = m + 1;
      tbl.push_back(mk(0, 0, 1, 0, 0, h < 8,
                       h < 7 ? 11 + h : (h == 7 ? 30 : 0),
                       h < 7 ? h + 1 : (h == 7 ? 30 : 0),
                       7 - m, 1, 1, 1));
    end
    foreach (tbl[i]) begin
      issue = tbl[i].iss; div_done = tbl[i].dn;
      out_ready = tbl[i].rdy;
      div_coc = tbl[i].coc; div_res = tbl[i].res;
      step();
      chk($sformatf("row%0d", i), snap(),
          {tbl[i].ev, tbl[i].ecoc, tbl[i].eres, tbl[i].eocc,
           tbl[i].ecan, tbl[i].eovf, tbl[i].eunf});
    end
    idle();

    // Forced issue past the credit limit.
    do_reset();
    chk("clean_after_reset", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b100});
    issue = 1;
    for (int i = 0; i < 8; i++) step();
    chk("eight_issued", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b000});
    step();
    issue = 0;
    chk("forced_issue_ovf", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b010});

    // Reset with three in flight, then a stray done.
    RSTa = 0;
    step();
    chk("can_in_reset", {71'd0, can_issue}, 72'd0);
    RSTa = 1;
    step();
    issue = 1;
    for (int i = 0; i < 3; i++) step();
    issue = 0;
    RSTa = 0;
    step();
    RSTa = 1;
    step();
    chk("reset_midop", snap(), {1'b0, 32'd0, 32'd0, 4'd0, 3'b100});
    div_done = 1; div_coc = 5; div_res = 6;
    step();
    div_done = 0;
    chk("stray_done_unf", snap(), {1'b1, 32'd5, 32'd6, 4'd1, 3'b101});

    // Random traffic against a fixed-latency divider model.
    do_reset();
    infl = 0;
    viol = 0;
    for (int t = 0; t < 10200; t++) begin
      pend_t p;
      if (int'(occupancy) + infl > D) viol++;
      issue = (t < 10000) && can_issue && ($urandom_range(0, 3) != 0);
      if (issue) begin
        if (t == 0) begin
          num = -9; den = 2;
        end else begin
          num = int'($urandom_range(0, 2000000)) - 1000000;
          den = int'($urandom_range(1, 50));
          if ($urandom_range(0, 1) == 1) den = -den;
        end
        p.due = t + LAT;
        p.coc = W'(num / den);
        p.res = W'(num % den);
        pend.push_back(p);
        sb.push_back(p);
        infl++;
      end
      div_done = 0;
      if (pend.size() > 0 && pend[0].due == t) begin
        p = pend.pop_front();
        div_done = 1; div_coc = p.coc; div_res = p.res;
        infl--;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underrun", 72'(1), 72'(0));
        end else begin
          p = sb.pop_front();
          chk("rand_pop", {8'd0, out_coc, out_res}, {8'd0, p.coc, p.res});
        end
      end
      step();
    end
    idle();
    chk("credit_bound", 72'(viol), 72'd0);
    chk("rand_drained", {62'd0, 8'(sb.size()), occupancy},
        {62'd0, 8'd0, 4'd0});
    chk("rand_no_err", {70'd0, err_ovf, err_unf}, 72'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
